// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges two req/ack write requesters onto the single
// register-file write port. Grants are combinational acks; the selected
// address/data are registered and presented one cycle later with a
// single-cycle write strobe.
module wb_write_arbiter #(
   parameter int WIDTH    = 32,
   parameter int AW       = 4,
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             req1,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] din1,
   output logic             ack1,
   input  logic             req2,
   input  logic [AW-1:0]    addr2,
   input  logic [WIDTH-1:0] din2,
   output logic             ack2,
   output logic             wen,
   output logic [AW-1:0]    waddr,
   output logic [WIDTH-1:0] wdata,
   output logic             busy
);

   localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
   localparam bit         C_RR       = (RR_MODE != 0);

   logic             w_allow;
   logic             w_pick2;
   logic             w_ack1;
   logic             w_ack2;

   // r_last2 = 1 means port 2 received the most recent grant
   logic             r_last2;
   logic [3:0]       r_wait_cnt;
   logic             r_wen;
   logic [AW-1:0]    r_waddr;
   logic [WIDTH-1:0] r_wdata;

   // Grant decision: when both request, w_pick2 decides the winner
   always_comb begin
      w_allow = ~hold & ~reset;
      w_pick2 = C_RR ? ~r_last2 : (r_wait_cnt == C_MAX_WAIT);
      w_ack1  = w_allow & req1 & ~(req2 & w_pick2);
      w_ack2  = w_allow & req2 & (~req1 | w_pick2);
   end

   // Round-robin pointer: remembers which port won last
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last2 <= 1'b1;
      end else if (w_ack1) begin
         r_last2 <= 1'b0;
      end else if (w_ack2) begin
         r_last2 <= 1'b1;
      end
   end

   // Starvation guard: counts cycles port 2 lost to port 1, saturating
   always_ff @(posedge clk) begin
      if (reset || C_RR) begin
         r_wait_cnt <= 4'd0;
      end else if (w_ack2) begin
         r_wait_cnt <= 4'd0;
      end else if (w_ack1 && req2 && (r_wait_cnt != C_MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end

   // Output stage: capture the granted write, pulse wen for one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_ack1) begin
         r_wen   <= 1'b1;
         r_waddr <= addr1;
         r_wdata <= din1;
      end else if (w_ack2) begin
         r_wen   <= 1'b1;
         r_waddr <= addr2;
         r_wdata <= din2;
      end else begin
         r_wen   <= 1'b0;
      end
   end

   assign ack1  = w_ack1;
   assign ack2  = w_ack2;
   assign wen   = r_wen;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
   assign busy  = (req1 & ~w_ack1) | (req2 & ~w_ack2);

endmodule
